// File: rtl/axi_mem_bist.sv
// AXI4 memory BIST master: fills the slave with seed+i using INCR write bursts,
// then reads it back with INCR read bursts and checks every beat.
module axi_mem_bist #(
  parameter int                     G_DATAWIDTH = 32,
  parameter int                     G_ADDRWIDTH = 32,
  parameter int                     G_MEMDEPTH  = 1024,
  parameter int                     G_BURSTLEN  = 16,
  parameter logic [G_ADDRWIDTH-1:0] G_BASEADDR  = '0
) (
  input  logic                     s_aclk,
  input  logic                     s_aresetn,
  input  logic                     start,
  input  logic [G_DATAWIDTH-1:0]   seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              err_count,
  output logic [G_ADDRWIDTH-1:0]   first_err_addr,
  output logic [0:0]               m_axi_awid,
  output logic [G_ADDRWIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [G_DATAWIDTH-1:0]   m_axi_wdata,
  output logic [G_DATAWIDTH/8-1:0] m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [0:0]               m_axi_bid,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [0:0]               m_axi_arid,
  output logic [G_ADDRWIDTH-1:0]   m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [0:0]               m_axi_rid,
  input  logic [G_DATAWIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int BYTES = G_DATAWIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int WW    = $clog2(G_MEMDEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [WW-1:0]            word_q, word_d;
  logic [7:0]               beat_q, beat_d;
  logic [7:0]               len_q, len_d;
  logic [G_ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [G_DATAWIDTH-1:0]   seed_q, seed_d;
  logic [G_DATAWIDTH-1:0]   pat_q, pat_d;
  logic [15:0]              err_q, err_d;
  logic [G_ADDRWIDTH-1:0]   first_q, first_d;
  logic                     busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                     awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic                     bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;

  logic                     start_ok, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic                     last_beat, more_words, wr_err, rd_err;
  logic [WW-1:0]            next_word;
  logic [G_ADDRWIDTH-1:0]   err_addr;

  // Burst length for a burst starting at word w: clipped to the words left.
  function automatic logic [7:0] len_for(input logic [WW-1:0] w);
    int rem;
    rem = G_MEMDEPTH - int'(w);
    if (rem > G_BURSTLEN) rem = G_BURSTLEN;
    return 8'(rem - 1);
  endfunction

  function automatic logic [G_ADDRWIDTH-1:0] addr_for(input logic [WW-1:0] w);
    return G_BASEADDR + (G_ADDRWIDTH'(w) << SIZE);
  endfunction

  assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign aw_fire    = awvalid_q && m_axi_awready;
  assign w_fire     = wvalid_q && m_axi_wready;
  assign b_fire     = bready_q && m_axi_bvalid;
  assign ar_fire    = arvalid_q && m_axi_arready;
  assign r_fire     = rready_q && m_axi_rvalid;
  assign last_beat  = (beat_q == len_q);
  assign next_word  = word_q + WW'(len_q) + WW'(1);
  assign more_words = (next_word < WW'(G_MEMDEPTH));
  assign wr_err     = b_fire && (m_axi_bresp != 2'b00);
  assign rd_err     = r_fire && ((m_axi_rdata != pat_q) || (m_axi_rresp != 2'b00) ||
                                 (m_axi_rlast != last_beat));
  // Write-response errors are attributed to the burst start, read errors to the beat.
  assign err_addr   = wr_err ? addr_q : addr_for(word_q + WW'(beat_q));

  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      seed_q    <= '0;
      pat_q     <= '0;
      err_q     <= '0;
      first_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      seed_q    <= seed_d;
      pat_q     <= pat_d;
      err_q     <= err_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start)                state_d = S_WR_ADDR;
      S_WR_ADDR:      if (aw_fire)              state_d = S_WR_DATA;
      S_WR_DATA:      if (w_fire && last_beat)  state_d = S_WR_RESP;
      S_WR_RESP:      if (b_fire)               state_d = more_words ? S_WR_ADDR : S_RD_ADDR;
      S_RD_ADDR:      if (ar_fire)              state_d = S_RD_DATA;
      S_RD_DATA:      if (r_fire && last_beat)  state_d = more_words ? S_RD_ADDR : S_DONE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    word_d  = word_q;
    beat_d  = beat_q;
    len_d   = len_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    pat_d   = pat_q;
    err_d   = err_q;
    first_d = first_q;
    if (start_ok) begin
      seed_d  = seed;
      pat_d   = seed;
      word_d  = '0;
      beat_d  = '0;
      len_d   = len_for('0);
      addr_d  = G_BASEADDR;
      err_d   = '0;
      first_d = '0;
    end else begin
      if (wr_err || rd_err) begin
        if (err_q == 16'd0)     first_d = err_addr;
        if (err_q != 16'hFFFF)  err_d   = err_q + 16'd1;
      end
      case (state_q)
        S_WR_DATA: begin
          if (w_fire) begin
            pat_d  = pat_q + G_DATAWIDTH'(1);
            beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
          end
        end
        S_WR_RESP: begin
          if (b_fire) begin
            if (more_words) begin
              word_d = next_word;
              len_d  = len_for(next_word);
              addr_d = addr_for(next_word);
            end else begin
              word_d = '0;
              len_d  = len_for('0);
              addr_d = G_BASEADDR;
              pat_d  = seed_q;
            end
          end
        end
        S_RD_DATA: begin
          if (r_fire) begin
            pat_d  = pat_q + G_DATAWIDTH'(1);
            beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
            if (last_beat && more_words) begin
              word_d = next_word;
              len_d  = len_for(next_word);
              addr_d = addr_for(next_word);
            end
          end
        end
        default: ;
      endcase
    end
    awvalid_d = (state_d == S_WR_ADDR);
    wvalid_d  = (state_d == S_WR_DATA);
    wlast_d   = (state_d == S_WR_DATA) && (beat_d == len_d);
    bready_d  = (state_d == S_WR_RESP);
    arvalid_d = (state_d == S_RD_ADDR);
    rready_d  = (state_d == S_RD_DATA);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    pass_d    = (state_d == S_DONE) && (err_d == 16'd0);
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = pat_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  // Only one ID is ever issued, so returned IDs carry no information.
  logic unused_ids;
  assign unused_ids = &{1'b0, m_axi_bid, m_axi_rid};

endmodule
